// File: rtl/sine_phase_sequencer.sv
// ============================================================================
// Module   : sine_phase_sequencer
// Purpose  : Walks a half-sine table up and down to emit a full-period sine
//            stream on a valid/ready interface at a programmable sample rate.
//            Optional macro SINE_SIGNED_OUT_EN selects two's-complement output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sine_phase_sequencer #(
    parameter int SINE_SIZE      = 8,
    parameter int TABLE_SIZE     = 44,
    parameter int TABLE_REG_SIZE = 6,
    parameter int DIV_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [DIV_W-1:0]          div,
    input  logic [SINE_SIZE-1:0]      sine_wave [0:TABLE_SIZE-1],
    input  logic [TABLE_REG_SIZE-1:0] table_size,
    output logic [SINE_SIZE-1:0]      sample_out,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      period_start,
    output logic                      dir_down
);

    localparam logic [TABLE_REG_SIZE-1:0] LAST_MAX = TABLE_REG_SIZE'(TABLE_SIZE - 1);
    localparam logic [TABLE_REG_SIZE-1:0] IDX_ZERO = '0;
    localparam logic [TABLE_REG_SIZE-1:0] IDX_ONE  = TABLE_REG_SIZE'(1);
    localparam logic [DIV_W-1:0]          CNT_ZERO = '0;
    localparam logic [DIV_W-1:0]          CNT_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_t;

    state_t                      state_q;
    logic [TABLE_REG_SIZE-1:0]   last_q;
    logic [TABLE_REG_SIZE-1:0]   index_q;
    logic [DIV_W-1:0]            cnt_q;
    logic [SINE_SIZE-1:0]        sample_q;
    logic                        valid_q;
    logic                        pstart_q;
    logic                        down_q;

    logic [TABLE_REG_SIZE-1:0]   last_d;
    logic [SINE_SIZE-1:0]        sample_d;
    logic                        slot_free_d;
    logic                        fire_d;

    assign last_d      = (table_size > LAST_MAX) ? LAST_MAX : table_size;
    assign slot_free_d = !valid_q || sample_ready;
    assign fire_d      = (cnt_q == div) && slot_free_d;

`ifdef SINE_SIGNED_OUT_EN
    // Flipping the MSB recentres the 0..255 table around zero.
    assign sample_d = sine_wave[index_q] ^ {1'b1, {(SINE_SIZE-1){1'b0}}};
`else
    assign sample_d = sine_wave[index_q];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= IDX_ZERO;
            index_q  <= IDX_ZERO;
            cnt_q    <= CNT_ZERO;
            sample_q <= '0;
            valid_q  <= 1'b0;
            pstart_q <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RISE;
                        last_q  <= last_d;
                        index_q <= IDX_ZERO;
                        cnt_q   <= CNT_ZERO;
                    end
                end
                default: begin
                    if (!enable) begin
                        state_q  <= IDLE;
                        index_q  <= IDX_ZERO;
                        cnt_q    <= CNT_ZERO;
                        valid_q  <= 1'b0;
                        pstart_q <= 1'b0;
                    end else if (fire_d) begin
                        sample_q <= sample_d;
                        valid_q  <= 1'b1;
                        pstart_q <= (index_q == IDX_ZERO);
                        down_q   <= (state_q == FALL);
                        cnt_q    <= CNT_ZERO;
                        if (state_q == RISE) begin
                            if (index_q == last_q) begin
                                // With last<=1 the falling leg has no samples.
                                if (last_q <= IDX_ONE) begin
                                    state_q <= RISE;
                                    index_q <= IDX_ZERO;
                                end else begin
                                    state_q <= FALL;
                                    index_q <= last_q - IDX_ONE;
                                end
                            end else begin
                                index_q <= index_q + IDX_ONE;
                            end
                        end else begin
                            if (index_q == IDX_ONE) begin
                                state_q <= RISE;
                                index_q <= IDX_ZERO;
                            end else begin
                                index_q <= index_q - IDX_ONE;
                            end
                        end
                    end else begin
                        // Counter parks at div while the consumer stalls.
                        if (cnt_q != div) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                        if (valid_q && sample_ready) begin
                            valid_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign period_start = pstart_q;
    assign dir_down     = down_q;

endmodule

`default_nettype wire

// File: doc/sine_phase_sequencer.md
Name: sine_phase_sequencer

Overview:
- Consumes the 44-entry, 8-bit half-sine table (raised half-cosine, 0 -> 255) and the table's last-index output.
- Walks the table up, then back down, to produce a continuous full-period sine sample stream at a programmable sample rate.
- Output is a valid/ready stream feeding the downstream DAC/PWM stage.
- Stalls without dropping samples when the consumer back-pressures.

Parameters:
- SINE_SIZE, 8, sample width; matches the table entry width.
- TABLE_SIZE, 44, number of table entries.
- TABLE_REG_SIZE, 6, width of index and of the table_size input.
- DIV_W, 16, width of the sample-rate divisor.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run request; low forces return to IDLE.
- div  input  DIV_W  clocks between samples minus 1; 0 = one sample per clock.
- sine_wave  input  SINE_SIZE x [0:TABLE_SIZE-1]  table contents.
- table_size  input  TABLE_REG_SIZE  last valid table index.
- sample_out  output  SINE_SIZE  current sample.
- sample_valid  output  1  sample_out holds an unaccepted sample.
- sample_ready  input  1  consumer accepts when valid && ready at a clock edge.
- period_start  output  1  high with a sample whose index is 0 (trough).
- dir_down  output  1  0 while rising, 1 while falling.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, index=0, rate counter=0, sample_out=0, sample_valid=0, period_start=0, dir_down=0.
- States: IDLE, RISE, FALL.
- IDLE -> RISE
  - On a clock with enable=1.
  - Latch last = min(table_size, TABLE_SIZE-1); table_size changes later are ignored until the next IDLE exit.
  - index=0, counter=0.
- Rate counter
  - Increments each clock in RISE/FALL.
  - When counter==div and the output slot is free (!sample_valid || sample_ready): load sample_out=sine_wave[index], assert sample_valid, period_start=(index==0), dir_down = (state==FALL), advance index, counter=0.
  - If the slot is not free, counter holds at div; phase does not advance and no sample is skipped.
- Index walk (full period = 2*last samples): emitted order 0,1,...,last (RISE), then last-1,...,1 (FALL), then 0, repeat.
  - RISE: after emitting index==last, go to FALL with index=last-1.
  - FALL: after emitting index==1, go to RISE with index=0.
  - Peak and trough each appear exactly once per period.
- Degenerate last=0: stay in RISE, every sample is sine_wave[0], period_start=1 on each sample.
- Degenerate last=1: sequence 0,1,0,1,...; FALL emits nothing, so transition RISE->RISE with index=0.
- Acceptance: sample_valid && sample_ready with no new load in the same cycle -> sample_valid=0 next cycle.
- Simultaneous accept and load: sample_valid stays 1 and the new sample replaces the old, so back-to-back throughput is 1/clk when div=0.
- enable=0 in RISE/FALL: next clock state=IDLE, sample_valid=0, period_start=0, index=0, counter=0. A pending unaccepted sample is discarded; sample_out holds its last value.
- First sample: enable rises at edge N -> with div=0, sample_valid=1 and sample_out=sine_wave[0] after edge N+1; with div=D, after edge N+1+D.
- Width rules: counter compare is unsigned and full DIV_W; index never exceeds last.

Optional Feature:
- Macro: SINE_SIGNED_OUT_EN.
- Defined: sample_out is two's-complement centred, i.e. the table value with its MSB inverted (0 -> 0x80/-128, 128 -> 0x00, 255 -> 0x7F/+127). Timing is unchanged.
- Undefined: sample_out is the unsigned table value, unmodified.

Test Plan:
- Reset mid-run: assert rst_n=0 while in FALL with sample_valid=1 -> all outputs read 0 immediately, without waiting for a clock edge; after release with enable=1, the first sample is sine_wave[0].
- Full period, div=0, ready=1, table_size=43: 86 consecutive samples 0,0,2,3,...,253,255,253,...,2,0. period_start asserts only on the 1st and 87th samples; dir_down=1 for samples 45-86.
- Rate: div=4, ready=1 -> sample_valid pulses every 5 clocks.
- Back-pressure: div=0, ready=1 for 10 samples, then ready=0 for 7 clocks, then ready=1 -> sample_out and sample_valid hold across the stall; the sequence resumes with no skipped or repeated index.
- Boundaries: table_size=60 -> behaves as 43 (clamped). table_size=0 -> constant sine_wave[0] with period_start=1 on every sample. table_size=1 -> sequence alternates 0,0,0,... (the values of entries 0 and 1).
- enable dropped mid-RISE at index 20 -> next cycle sample_valid=0; re-enable restarts at index 0 with period_start=1. With SINE_SIGNED_OUT_EN defined, the peak reads 0x7F and the trough reads 0x80.
